// File: rtl/pipe_stage_reg_pkg.sv
// Y86 shared definitions used by the generic inter-stage pipeline register.
// Provides the status codes, the icode list and the exception test.
package pipe_stage_reg_pkg;

    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    // Any status other than a normal instruction or a bubble is an exception.
    function automatic logic is_exception(input logic [2:0] stat);
        return (stat != STAT_AOK) && (stat != STAT_BUB);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between a pipeline stage and its inter-stage register.
// The master drives the upstream fields and control; the register is the slave.
interface pipe_stage_reg_if #(
    parameter int W     = 64,
    parameter int NVAL  = 2,
    parameter int NDST  = 2,
    parameter int CNT_W = 16
);
    logic                stall;
    logic                bubble;
    logic [2:0]          i_stat;
    logic [3:0]          i_icode;
    logic                i_cnd;
    logic [NVAL*W-1:0]   i_val;
    logic [NDST*4-1:0]   i_dst;
    logic [2:0]          o_stat;
    logic [3:0]          o_icode;
    logic                o_cnd;
    logic [NVAL*W-1:0]   o_val;
    logic [NDST*4-1:0]   o_dst;
    logic                o_frozen;
    logic                o_ctl_err;
    logic [CNT_W-1:0]    o_stall_cnt;
    logic [CNT_W-1:0]    o_bub_cnt;

    modport master (
        output stall, bubble, i_stat, i_icode, i_cnd, i_val, i_dst,
        input  o_stat, o_icode, o_cnd, o_val, o_dst,
               o_frozen, o_ctl_err, o_stall_cnt, o_bub_cnt
    );

    modport slave (
        input  stall, bubble, i_stat, i_icode, i_cnd, i_val, i_dst,
        output o_stat, o_icode, o_cnd, o_val, o_dst,
               o_frozen, o_ctl_err, o_stall_cnt, o_bub_cnt
    );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + ONE;
        end
    end

    assign cnt = cnt_reg;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic Y86 inter-stage pipeline register with load, stall, bubble and
// exception freeze, plus saturating stall/bubble event counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int W      = 64,
    parameter int NVAL   = 2,
    parameter int NDST   = 2,
    parameter int CNT_W  = 16,
    parameter bit FREEZE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_stage_reg_if.slave bus
);
    localparam logic [NDST*4-1:0] DST_NONE = {NDST{RNONE}};

    logic [2:0]        stat_reg;
    logic [3:0]        icode_reg;
    logic              cnd_reg;
    logic [NVAL*W-1:0] val_reg;
    logic [NDST*4-1:0] dst_reg;
    logic              frozen_reg;
    logic              ctl_err_reg;

    logic              frozen_next;
    logic              ctl_err_next;
    logic              do_bubble;
    logic              do_stall;
    logic              do_load;

    // A frozen register ignores every control input, so decode against it first.
    always_comb begin
        do_bubble    = !frozen_reg && bus.bubble;
        do_stall     = !frozen_reg && !bus.bubble && bus.stall;
        do_load      = !frozen_reg && !bus.bubble && !bus.stall;
        ctl_err_next = !frozen_reg && bus.bubble && bus.stall;
        frozen_next  = frozen_reg || (FREEZE && do_load && is_exception(bus.i_stat));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_reg    <= STAT_BUB;
            icode_reg   <= I_NOP;
            cnd_reg     <= 1'b0;
            val_reg     <= '0;
            dst_reg     <= DST_NONE;
            frozen_reg  <= 1'b0;
            ctl_err_reg <= 1'b0;
        end else begin
            frozen_reg  <= frozen_next;
            ctl_err_reg <= ctl_err_next;
            if (do_bubble) begin
                stat_reg  <= STAT_BUB;
                icode_reg <= I_NOP;
                cnd_reg   <= 1'b0;
                val_reg   <= '0;
                dst_reg   <= DST_NONE;
            end else if (do_load) begin
                stat_reg  <= bus.i_stat;
                icode_reg <= bus.i_icode;
                cnd_reg   <= bus.i_cnd;
                val_reg   <= bus.i_val;
                dst_reg   <= bus.i_dst;
            end
        end
    end

    // Counter 0 tracks stalls, counter 1 tracks bubbles.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc = {do_bubble, do_stall};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(.WIDTH(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (cnt_inc[gi]),
                .cnt   (cnt_val[gi])
            );
        end
    endgenerate

    assign bus.o_stat      = stat_reg;
    assign bus.o_icode     = icode_reg;
    assign bus.o_cnd       = cnd_reg;
    assign bus.o_val       = val_reg;
    assign bus.o_dst       = dst_reg;
    assign bus.o_frozen    = frozen_reg;
    assign bus.o_ctl_err   = ctl_err_reg;
    assign bus.o_stall_cnt = cnt_val[0];
    assign bus.o_bub_cnt   = cnt_val[1];
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: one default instance, one with FREEZE=0 and one with CNT_W=2,
// all driven by the same stimulus.
module tb_pipe_stage_reg;
    localparam int W = 64, NVAL = 2, NDST = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              stall, bubble, cnd;
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic [NVAL*W-1:0] val;
    logic [NDST*4-1:0] dst;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg_if #(.W(W), .NVAL(NVAL), .NDST(NDST), .CNT_W(16)) bus_a ();
    pipe_stage_reg_if #(.W(W), .NVAL(NVAL), .NDST(NDST), .CNT_W(16)) bus_nf ();
    pipe_stage_reg_if #(.W(W), .NVAL(NVAL), .NDST(NDST), .CNT_W(2))  bus_c2 ();

    assign {bus_a.stall,  bus_a.bubble,  bus_a.i_stat,  bus_a.i_icode,  bus_a.i_cnd,  bus_a.i_val,  bus_a.i_dst}  = {stall, bubble, stat, icode, cnd, val, dst};
    assign {bus_nf.stall, bus_nf.bubble, bus_nf.i_stat, bus_nf.i_icode, bus_nf.i_cnd, bus_nf.i_val, bus_nf.i_dst} = {stall, bubble, stat, icode, cnd, val, dst};
    assign {bus_c2.stall, bus_c2.bubble, bus_c2.i_stat, bus_c2.i_icode, bus_c2.i_cnd, bus_c2.i_val, bus_c2.i_dst} = {stall, bubble, stat, icode, cnd, val, dst};

    pipe_stage_reg #(.W(W), .NVAL(NVAL), .NDST(NDST), .CNT_W(16), .FREEZE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    pipe_stage_reg #(.W(W), .NVAL(NVAL), .NDST(NDST), .CNT_W(16), .FREEZE(1'b0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .bus(bus_nf));
    pipe_stage_reg #(.W(W), .NVAL(NVAL), .NDST(NDST), .CNT_W(2), .FREEZE(1'b1)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .bus(bus_c2));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic b, input logic [2:0] st,
                         input logic [3:0] ic, input logic c, input logic [63:0] v0,
                         input logic [7:0] d);
        stall  = s;
        bubble = b;
        stat   = st;
        icode  = ic;
        cnd    = c;
        val    = {64'h0, v0};
        dst    = d;
    endtask

    task automatic check_fields(input string tag, input logic [2:0] st, input logic [3:0] ic,
                                input logic c, input logic [63:0] v0, input logic [7:0] d);
        check({tag, ".stat"},  128'(bus_a.o_stat),  128'(st));
        check({tag, ".icode"}, 128'(bus_a.o_icode), 128'(ic));
        check({tag, ".cnd"},   128'(bus_a.o_cnd),   128'(c));
        check({tag, ".val"},   128'(bus_a.o_val),   {64'h0, v0});
        check({tag, ".dst"},   128'(bus_a.o_dst),   128'(d));
    endtask

    initial begin
        drive(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 64'h0, 8'h00);
        repeat (2) tick();

        // Reset state
        check_fields("reset", 3'd0, 4'h1, 1'b0, 64'h0, 8'hFF);
        check("reset.frozen",  128'(bus_a.o_frozen),    128'(0));
        check("reset.ctl_err", 128'(bus_a.o_ctl_err),   128'(0));
        check("reset.stall",   128'(bus_a.o_stall_cnt), 128'(0));
        check("reset.bub",     128'(bus_a.o_bub_cnt),   128'(0));
        #2 rst_n = 1'b1;

        // 1. Plain load, one-cycle latency
        drive(1'b0, 1'b0, 3'd1, 4'h6, 1'b1, 64'h10, 8'hF3);
        tick();
        check_fields("load", 3'd1, 4'h6, 1'b1, 64'h10, 8'hF3);
        check("load.frozen", 128'(bus_a.o_frozen),    128'(0));
        check("load.stall",  128'(bus_a.o_stall_cnt), 128'(0));
        check("load.bub",    128'(bus_a.o_bub_cnt),   128'(0));

        // 2. Three stalls with changing inputs
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 3'd1, 4'(k + 2), 1'b0, 64'(k + 32'h100), 8'(k + 8'h40));
            tick();
            check_fields($sformatf("stall%0d", k), 3'd1, 4'h6, 1'b1, 64'h10, 8'hF3);
        end
        check("stall.cnt",    128'(bus_a.o_stall_cnt),  128'(3));
        check("stall.bub",    128'(bus_a.o_bub_cnt),    128'(0));
        check("stall.cnt_c2", 128'(bus_c2.o_stall_cnt), 128'(3));

        // 3. Single bubble
        drive(1'b0, 1'b1, 3'd1, 4'h2, 1'b1, 64'h99, 8'h12);
        tick();
        check_fields("bubble", 3'd0, 4'h1, 1'b0, 64'h0, 8'hFF);
        check("bubble.bub",     128'(bus_a.o_bub_cnt), 128'(1));
        check("bubble.ctl_err", 128'(bus_a.o_ctl_err), 128'(0));

        // 4. Load, then stall+bubble together
        drive(1'b0, 1'b0, 3'd1, 4'h2, 1'b1, 64'h55, 8'h21);
        tick();
        check_fields("load2", 3'd1, 4'h2, 1'b1, 64'h55, 8'h21);
        drive(1'b1, 1'b1, 3'd1, 4'h3, 1'b1, 64'h66, 8'h34);
        tick();
        check_fields("both", 3'd0, 4'h1, 1'b0, 64'h0, 8'hFF);
        check("both.ctl_err", 128'(bus_a.o_ctl_err),   128'(1));
        check("both.stall",   128'(bus_a.o_stall_cnt), 128'(3));
        check("both.bub",     128'(bus_a.o_bub_cnt),   128'(2));
        drive(1'b0, 1'b0, 3'd1, 4'h3, 1'b0, 64'h77, 8'h45);
        tick();
        check("after.ctl_err", 128'(bus_a.o_ctl_err), 128'(0));
        check("after.icode",   128'(bus_a.o_icode),   128'(4'h3));

        // 6. Two more stalls: 5 total, CNT_W=2 instance saturates at 3
        drive(1'b1, 1'b0, 3'd1, 4'h4, 1'b0, 64'h0, 8'h00);
        repeat (2) tick();
        check("sat.cnt16", 128'(bus_a.o_stall_cnt),  128'(5));
        check("sat.cnt2",  128'(bus_c2.o_stall_cnt), 128'(3));

        // 5. Exception load freezes the FREEZE=1 instance only
        drive(1'b0, 1'b0, 3'd3, 4'h5, 1'b1, 64'h88, 8'hF2);
        tick();
        check_fields("exc", 3'd3, 4'h5, 1'b1, 64'h88, 8'hF2);
        check("exc.frozen",    128'(bus_a.o_frozen),  128'(1));
        check("exc.nf_frozen", 128'(bus_nf.o_frozen), 128'(0));
        drive(1'b0, 1'b0, 3'd1, 4'h6, 1'b0, 64'h11, 8'h33);
        tick();
        check_fields("frz_load", 3'd3, 4'h5, 1'b1, 64'h88, 8'hF2);
        check("frz_load.nf_icode", 128'(bus_nf.o_icode), 128'(4'h6));
        drive(1'b1, 1'b1, 3'd1, 4'h6, 1'b0, 64'h11, 8'h33);
        tick();
        check_fields("frz_bub", 3'd3, 4'h5, 1'b1, 64'h88, 8'hF2);
        check("frz_bub.bub",     128'(bus_a.o_bub_cnt),   128'(2));
        check("frz_bub.stall",   128'(bus_a.o_stall_cnt), 128'(5));
        check("frz_bub.nf_bub",  128'(bus_nf.o_bub_cnt),  128'(3));
        check("frz_bub.nf_stat", 128'(bus_nf.o_stat),     128'(0));

        // Mid-cycle asynchronous reset while frozen
        drive(1'b0, 1'b0, 3'd1, 4'h6, 1'b0, 64'h11, 8'h33);
        #2 rst_n = 1'b0;
        #1;
        check_fields("arst", 3'd0, 4'h1, 1'b0, 64'h0, 8'hFF);
        check("arst.frozen", 128'(bus_a.o_frozen),    128'(0));
        check("arst.stall",  128'(bus_a.o_stall_cnt), 128'(0));
        check("arst.bub",    128'(bus_a.o_bub_cnt),   128'(0));
        tick();
        #2 rst_n = 1'b1;
        tick();
        check_fields("post_rst", 3'd1, 4'h6, 1'b0, 64'h11, 8'h33);
        check("post_rst.frozen", 128'(bus_a.o_frozen), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
